// File: rtl/uart_tx_framer.sv
// UART transmit framer: a small byte FIFO feeding a bit-serialiser that is
// paced by rising edges of the baud generator's baud_clk, seen in the clk domain.
// Frame: start bit, DATA_BITS data bits LSB first, optional parity, 1 or 2 stop bits.
module uart_tx_framer #(
  parameter int DATA_BITS  = 8,  // 5..8
  parameter int PARITY     = 0,  // 0 none, 1 even, 2 odd
  parameter int STOP_BITS  = 1,  // 1 or 2
  parameter int FIFO_DEPTH = 4   // power of 2, >= 2
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              baud_clk,
  input  logic [DATA_BITS-1:0]              tx_data,
  input  logic                              tx_valid,
  output logic                              tx_ready,
  output logic                              tx,
  output logic                              tx_busy,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_count
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int BIT_W = $clog2(DATA_BITS);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PAR,
    S_STOP
  } state_t;

  // ---------------------------------------------------------------------------
  // Baud edge detection
  // ---------------------------------------------------------------------------
  logic baud_clk_q;
  logic bit_tick;

  // Delayed copy of baud_clk so its rising edge becomes a one-clk pulse.
  // NOTE: registers use non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) baud_clk_q <= 1'b0;
    else     baud_clk_q <= baud_clk;
  end

  assign bit_tick = baud_clk & ~baud_clk_q;

  // ---------------------------------------------------------------------------
  // Input FIFO
  // ---------------------------------------------------------------------------
  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]     wr_ptr_q;
  logic [PTR_W-1:0]     rd_ptr_q;
  logic [CNT_W-1:0]     count_q;
  logic                 push;
  logic                 pop;
  logic                 fifo_empty;
  logic [DATA_BITS-1:0] head;

  assign tx_ready   = (count_q != CNT_W'(FIFO_DEPTH));
  assign push       = tx_valid & tx_ready;
  assign fifo_empty = (count_q == '0);
  assign head       = mem[rd_ptr_q];
  assign fifo_count = count_q;

  // Storage array written on push.
  // NOTE: the data array has no reset; count and pointers alone define what is valid.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= tx_data;
  end

  // Pointers wrap naturally at FIFO_DEPTH; count saturates by construction of push/pop.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      unique case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Serialiser FSM
  // ---------------------------------------------------------------------------
  state_t               state_q, state_d;
  logic                 tx_q, tx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [BIT_W-1:0]     bit_cnt_q, bit_cnt_d;
  logic                 stop_cnt_q, stop_cnt_d;
  logic                 par_q, par_d;

  function automatic logic calc_parity(input logic [DATA_BITS-1:0] d);
    if (PARITY == 2) return ~^d;
    return ^d;
  endfunction

  // State and datapath registers; tx idles high and returns high immediately on reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      tx_q       <= 1'b1;
      shift_q    <= '0;
      bit_cnt_q  <= '0;
      stop_cnt_q <= 1'b0;
      par_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      tx_q       <= tx_d;
      shift_q    <= shift_d;
      bit_cnt_q  <= bit_cnt_d;
      stop_cnt_q <= stop_cnt_d;
      par_q      <= par_d;
    end
  end

  // Next-state logic: nothing moves except on a bit tick.
  // NOTE: every output gets a hold default first so no path leaves one unassigned (no latches).
  always_comb begin
    state_d    = state_q;
    tx_d       = tx_q;
    shift_d    = shift_q;
    bit_cnt_d  = bit_cnt_q;
    stop_cnt_d = stop_cnt_q;
    par_d      = par_q;
    pop        = 1'b0;
    if (bit_tick) begin
      unique case (state_q)
        S_IDLE: begin
          if (!fifo_empty) begin
            pop     = 1'b1;
            shift_d = head;
            par_d   = calc_parity(head);
            tx_d    = 1'b0;
            state_d = S_START;
          end else begin
            tx_d = 1'b1;
          end
        end
        S_START: begin
          tx_d      = shift_q[0];
          shift_d   = shift_q >> 1;
          bit_cnt_d = '0;
          state_d   = S_DATA;
        end
        S_DATA: begin
          if (bit_cnt_q == BIT_W'(DATA_BITS - 1)) begin
            if (PARITY != 0) begin
              tx_d    = par_q;
              state_d = S_PAR;
            end else begin
              tx_d       = 1'b1;
              stop_cnt_d = 1'b0;
              state_d    = S_STOP;
            end
          end else begin
            tx_d      = shift_q[0];
            shift_d   = shift_q >> 1;
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end
        S_PAR: begin
          tx_d       = 1'b1;
          stop_cnt_d = 1'b0;
          state_d    = S_STOP;
        end
        S_STOP: begin
          if (stop_cnt_q == 1'(STOP_BITS - 1)) begin
            // Chain straight into the next start bit when more data is waiting.
            if (!fifo_empty) begin
              pop     = 1'b1;
              shift_d = head;
              par_d   = calc_parity(head);
              tx_d    = 1'b0;
              state_d = S_START;
            end else begin
              tx_d    = 1'b1;
              state_d = S_IDLE;
            end
          end else begin
            stop_cnt_d = stop_cnt_q + 1'b1;
            tx_d       = 1'b1;
          end
        end
        default: begin
          tx_d    = 1'b1;
          state_d = S_IDLE;
        end
      endcase
    end
  end

  assign tx      = tx_q;
  assign tx_busy = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_tx_framer.sv
// Testbench for uart_tx_framer: three instances (no parity / even / odd + 2 stop bits)
// share clk, rst and baud_clk. A bit-level UART receiver samples each line once per
// baud period (at the baud_clk falling edge, mid-bit) and checks decoded frames
// against a scoreboard of bytes queued when they were pushed.
module tb_uart_tx_framer;

  localparam int N  = 3;
  localparam int DB = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       baud_clk = 1'b0;
  logic [7:0] tx_data  [N];
  logic       tx_valid [N];
  logic       tx_ready [N];
  logic       tx_line  [N];
  logic       tx_busy  [N];
  logic [2:0] fifo_count [N];

  int vectors = 0;
  int miscompares = 0;

  uart_tx_framer u0 (
    .clk(clk), .rst(rst), .baud_clk(baud_clk),
    .tx_data(tx_data[0]), .tx_valid(tx_valid[0]), .tx_ready(tx_ready[0]),
    .tx(tx_line[0]), .tx_busy(tx_busy[0]), .fifo_count(fifo_count[0]));

  uart_tx_framer #(.PARITY(1)) u1 (
    .clk(clk), .rst(rst), .baud_clk(baud_clk),
    .tx_data(tx_data[1]), .tx_valid(tx_valid[1]), .tx_ready(tx_ready[1]),
    .tx(tx_line[1]), .tx_busy(tx_busy[1]), .fifo_count(fifo_count[1]));

  uart_tx_framer #(.PARITY(2), .STOP_BITS(2)) u2 (
    .clk(clk), .rst(rst), .baud_clk(baud_clk),
    .tx_data(tx_data[2]), .tx_valid(tx_valid[2]), .tx_ready(tx_ready[2]),
    .tx(tx_line[2]), .tx_busy(tx_busy[2]), .fifo_count(fifo_count[2]));

  always #5 clk = ~clk;

  function automatic int par_cfg(input int i);
    return (i == 0) ? 0 : i;
  endfunction

  function automatic int stop_cfg(input int i);
    return (i == 2) ? 2 : 1;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Scoreboard
  // ---------------------------------------------------------------------------
  typedef struct {
    int         inst;
    logic [7:0] data;
  } exp_t;

  exp_t sb[$];

  task automatic sb_push(input int i, input logic [7:0] d);
    exp_t e;
    e.inst = i;
    e.data = d;
    sb.push_back(e);
  endtask

  task automatic sb_pop(input int i, output logic found, output logic [7:0] d);
    found = 1'b0;
    d     = '0;
    for (int k = 0; k < sb.size(); k++) begin
      if (sb[k].inst == i) begin
        found = 1'b1;
        d     = sb[k].data;
        sb.delete(k);
        break;
      end
    end
  endtask

  // ---------------------------------------------------------------------------
  // Receiver model: one sample per baud period
  // ---------------------------------------------------------------------------
  logic       rx_en = 1'b0;
  int         rx_phase [N];  // 0 idle, 1 data, 2 parity, 3 stop
  int         rx_idx   [N];
  int         rx_stop  [N];
  int         rx_gap   [N];
  int         gap_sum  [N];
  int         frames   [N];
  logic [7:0] rx_shift [N];
  logic       rx_par   [N];

  task automatic rx_reset(input int i);
    rx_phase[i] = 0;
    rx_idx[i]   = 0;
    rx_stop[i]  = 0;
    rx_gap[i]   = 0;
    gap_sum[i]  = 0;
    frames[i]   = 0;
  endtask

  task automatic finish_frame(input int i);
    logic       found;
    logic [7:0] d;
    logic       exp_par;
    sb_pop(i, found, d);
    check($sformatf("frame_expected_u%0d", i), found, 1);
    if (found) begin
      check($sformatf("data_u%0d", i), rx_shift[i], d);
      if (par_cfg(i) != 0) begin
        exp_par = (par_cfg(i) == 1) ? ^d : ~^d;
        check($sformatf("parity_u%0d_%02h", i, d), rx_par[i], exp_par);
      end
    end
    frames[i]++;
    rx_phase[i] = 0;
    rx_gap[i]   = 0;
  endtask

  task automatic rx_sample(input int i, input logic b);
    case (rx_phase[i])
      0: begin
        if (b === 1'b0) begin
          if (frames[i] > 0) gap_sum[i] += rx_gap[i];
          rx_gap[i]   = 0;
          rx_idx[i]   = 0;
          rx_phase[i] = 1;
        end else begin
          rx_gap[i]++;
        end
      end
      1: begin
        rx_shift[i][rx_idx[i]] = b;
        rx_idx[i]++;
        if (rx_idx[i] == DB) begin
          rx_stop[i]  = 0;
          rx_phase[i] = (par_cfg(i) != 0) ? 2 : 3;
        end
      end
      2: begin
        rx_par[i]   = b;
        rx_stop[i]  = 0;
        rx_phase[i] = 3;
      end
      default: begin
        check($sformatf("stop_bit_u%0d", i), b, 1);
        rx_stop[i]++;
        if (rx_stop[i] == stop_cfg(i)) finish_frame(i);
      end
    endcase
  endtask

  // ---------------------------------------------------------------------------
  // Baud generator: toggles every 4 clk; can be frozen high right after a rise
  // ---------------------------------------------------------------------------
  logic hold_req = 1'b0;
  logic holding  = 1'b0;

  initial begin
    forever begin
      repeat (4) @(posedge clk);
      #1 baud_clk = 1'b1;
      while (hold_req) begin
        holding = 1'b1;
        @(posedge clk);
      end
      holding = 1'b0;
      repeat (4) @(posedge clk);
      #1 baud_clk = 1'b0;
      if (rx_en) for (int i = 0; i < N; i++) rx_sample(i, tx_line[i]);
    end
  end

  // Bench-side view of the bit tick: baud_clk newly high at this clk edge.
  logic tb_tick = 1'b0;
  logic tb_bq   = 1'b0;
  always @(posedge clk) begin
    tb_tick = baud_clk & ~tb_bq;
    tb_bq   = baud_clk;
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------------
  task automatic drive(input int i, input logic [7:0] d);
    tx_data[i]  = d;
    tx_valid[i] = 1'b1;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) tx_valid[i] = 1'b0;
  endtask

  task automatic wait_frames(input int i, input int n, input int budget);
    int t = 0;
    while (frames[i] < n && t < budget) begin
      @(posedge clk);
      #1;
      t++;
    end
    check($sformatf("frames_done_u%0d", i), frames[i], n);
  endtask

  task automatic wait_idle(input int i, input int budget);
    int t = 0;
    while (tx_busy[i] !== 1'b0 && t < budget) begin
      @(posedge clk);
      #1;
      t++;
    end
    check($sformatf("idle_u%0d", i), tx_busy[i], 0);
    check($sformatf("idle_tx_u%0d", i), tx_line[i], 1);
  endtask

  task automatic wait_rx_bit(input int i, input int idx, input int budget);
    int t = 0;
    while (!(rx_phase[i] == 1 && rx_idx[i] == idx) && t < budget) begin
      @(posedge clk);
      #1;
      t++;
    end
    check($sformatf("reach_bit%0d_u%0d", idx, i), rx_idx[i], idx);
  endtask

  task automatic check_reset_state(input string tag);
    for (int i = 0; i < N; i++) begin
      check($sformatf("%s_tx_u%0d", tag, i), tx_line[i], 1);
      check($sformatf("%s_busy_u%0d", tag, i), tx_busy[i], 0);
      check($sformatf("%s_ready_u%0d", tag, i), tx_ready[i], 1);
      check($sformatf("%s_count_u%0d", tag, i), fifo_count[i], 0);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Test sequence
  // ---------------------------------------------------------------------------
  initial begin
    logic [7:0] burst [5];
    logic       early;
    logic       exp_ready;
    logic       tx_seen, busy_seen;
    int         model_cnt;
    int         t;
    int         changes;

    for (int i = 0; i < N; i++) begin
      tx_data[i]  = '0;
      tx_valid[i] = 1'b0;
      rx_reset(i);
    end

    // 1. Reset
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check_reset_state("rst");
    repeat (20) @(posedge clk);
    #1;
    check_reset_state("rst_hold");
    rx_en = 1'b1;

    // 2. Single 0xA5 frame on the no-parity instance, start on first tick after push
    sb_push(0, 8'hA5);
    drive(0, 8'hA5);
    step();
    early = 1'b0;
    t = 0;
    while (t < 20) begin
      @(posedge clk);
      #1;
      t++;
      if (tb_tick) break;
      if (tx_line[0] !== 1'b1) early = 1'b1;
    end
    check("a5_no_early_start", early, 0);
    check("a5_start_on_tick", tx_line[0], 0);
    check("a5_busy", tx_busy[0], 1);
    wait_frames(0, 1, 150);
    wait_idle(0, 40);

    // 3. Parity and two stop bits, two frames back to back on u1/u2
    rx_reset(1);
    rx_reset(2);
    sb_push(1, 8'h07); sb_push(2, 8'h07);
    drive(1, 8'h07);   drive(2, 8'h07);
    step();
    sb_push(1, 8'h5A); sb_push(2, 8'h5A);
    drive(1, 8'h5A);   drive(2, 8'h5A);
    step();
    wait_frames(1, 2, 400);
    wait_frames(2, 2, 400);
    check("par_gap_u1", gap_sum[1], 0);
    check("par_gap_u2", gap_sum[2], 0);
    wait_idle(1, 40);
    wait_idle(2, 40);

    // 4. Five pushes on consecutive clks right after a tick: four fit
    rx_reset(0);
    burst = '{8'h11, 8'hC3, 8'h80, 8'h3E, 8'hFF};
    t = 0;
    while (!tb_tick && t < 20) begin
      @(posedge clk);
      #1;
      t++;
    end
    model_cnt = 0;
    for (int k = 0; k < 5; k++) begin
      exp_ready = (model_cnt != 4);
      drive(0, burst[k]);
      check($sformatf("burst_ready%0d", k), tx_ready[0], exp_ready);
      if (exp_ready) begin
        sb_push(0, burst[k]);
        model_cnt++;
      end
      step();
    end
    check("burst_count", fifo_count[0], 4);
    check("burst_full_ready", tx_ready[0], 0);
    wait_frames(0, 4, 500);
    check("burst_gap", gap_sum[0], 0);
    repeat (120) @(posedge clk);
    #1;
    check("burst_no_extra", frames[0], 4);

    // 5. Reset during data bit 3 with two bytes still queued
    rx_reset(0);
    for (int k = 0; k < 3; k++) begin
      sb_push(0, 8'h96 + 8'(k));
      drive(0, 8'h96 + 8'(k));
      step();
    end
    wait_rx_bit(0, 4, 200);
    check("rst_mid_count", fifo_count[0], 2);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    check("rst_mid_tx", tx_line[0], 1);
    check("rst_mid_count0", fifo_count[0], 0);
    check("rst_mid_busy", tx_busy[0], 0);
    sb.delete();
    for (int i = 0; i < N; i++) rx_reset(i);
    tx_seen = 1'b1;
    repeat (300) begin
      @(posedge clk);
      #1;
      tx_seen &= tx_line[0];
    end
    check("rst_mid_line_high", tx_seen, 1);
    check("rst_mid_no_frames", frames[0], 0);

    // 6. Freeze baud_clk high during data bit 3 of 0x3C
    rx_reset(0);
    sb_push(0, 8'h3C);
    drive(0, 8'h3C);
    step();
    wait_rx_bit(0, 3, 200);
    hold_req = 1'b1;
    t = 0;
    while (!holding && t < 20) begin
      @(posedge clk);
      #1;
      t++;
    end
    check("hold_engaged", holding, 1);
    @(posedge clk);
    #1;
    tx_seen   = tx_line[0];
    busy_seen = tx_busy[0];
    changes   = 0;
    repeat (100) begin
      @(posedge clk);
      #1;
      if (tx_line[0] !== tx_seen || tx_busy[0] !== busy_seen) changes++;
    end
    check("hold_tx_bit3", tx_seen, 1);
    check("hold_busy", busy_seen, 1);
    check("hold_frozen", changes, 0);
    hold_req = 1'b0;
    wait_frames(0, 1, 200);
    wait_idle(0, 40);

    check("sb_drained", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
